blk2s_pre: RTL and testbench
============================

// Module: blk2s_pre
// PURPOSE
//  Feed stage ahead of BLK2S; the opposite end of the buf_ptr link driven by BLK2S_POST.
//  Holds a 256-byte message buffer and accepts an 8-bit buffer pointer over a vld/rdy handshake.
//  Gathers BLK_BYTES consecutive bytes starting at that pointer, wrapping mod 256, at BEAT_BYTES per cycle.
//  Presents the assembled block plus a block counter to BLK2S over a second vld/rdy handshake.
// PARAMETERS
//  BLK_BYTES   64  bytes per block sent to BLK2S; must be an integer multiple of BEAT_BYTES
//  BEAT_BYTES  8   bytes gathered per FETCH cycle; NB = BLK_BYTES/BEAT_BYTES beats per block
// PORTS
//  clk        in   1              clock; all state updates on the rising edge
//  rst_n      in   1              asynchronous reset, active low
//  wr_en      in   1              buffer byte write strobe
//  wr_addr    in   8              buffer byte address
//  wr_data    in   8              buffer byte data
//  kick       in   1              start pulse: fetch from ptr 0 and clear blk_cnt
//  in_vld     in   1              buf_ptr valid (from BLK2S_POST out_vld)
//  in_rdy     out  1              buf_ptr accepted when in_vld & in_rdy
//  buf_ptr    in   8              start byte address of the next block
//  out_vld    out  1              blk_data / blk_cnt valid toward BLK2S
//  out_rdy    in   1              BLK2S accepts the block when out_vld & out_rdy
//  blk_data   out  BLK_BYTES*8    assembled block; byte k is blk_data[8k+:8]
//  blk_cnt    out  32             index of the presented block since the last kick
//  busy       out  1              high whenever state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, out_vld=0, blk_data=0, blk_cnt=0, beat=0, ptr=0; busy=0, in_rdy=1.
//  Buffer array is not reset; its contents are undefined until written.
//  Write port is always live: on wr_en, buf[wr_addr] <= wr_data at the clock edge, in any state.
//  FSM states:
//   IDLE: in_rdy = ~kick.
//         On kick: ptr<=0, blk_cnt<=0, beat<=0, go to FETCH. kick has priority; a simultaneous in_vld is not accepted.
//         Else on in_vld: ptr<=buf_ptr, beat<=0, go to FETCH.
//   FETCH: in_rdy=0.
//         Each cycle, for j in 0..BEAT_BYTES-1, k=beat*BEAT_BYTES+j: blk_data[8k+:8] <= buf[(ptr+k) mod 256].
//         beat++. After beat NB-1, go to SEND with out_vld<=1.
//   SEND: in_rdy=0. out_vld=1; blk_data and blk_cnt are held stable while out_rdy=0.
//         On out_rdy: out_vld<=0, blk_cnt <= blk_cnt+1 (wraps at 2^32), go to IDLE.
//  Latency: acceptance at edge E makes out_vld high after edge E+NB.
//   Minimum period is NB+2 cycles per block, since IDLE lasts at least one cycle between blocks.
//  Read/write collision: a byte read in the same cycle it is written returns the old value.
//  Address arithmetic is 8-bit modulo, so ptr=0xF8 with k=8 reads buf[0x00].
//  kick outside IDLE is ignored. in_vld outside IDLE is not accepted and must be held by the source.
//  out_vld never drops before out_rdy.
//  Async reset mid-FETCH or mid-SEND returns all state to the reset values immediately; the partial block is discarded.
// TESTING
//  1. Write buf[i]=i for all i; kick -> out_vld after 8 cycles; blk_data byte k = k for k=0..63; blk_cnt=0.
//  2. In IDLE, buf_ptr=0xF0, in_vld=1 -> bytes 0xF0..0xFF then 0x00..0x2F; blk_cnt=1 after the first handshake.
//  3. Hold out_rdy=0 for 20 cycles in SEND, then toggle wr_en -> blk_data, blk_cnt and out_vld are stable; in_rdy=0 throughout.
//  4. Assert kick and in_vld in the same IDLE cycle -> ptr=0 is used, in_rdy=0 that cycle, blk_cnt=0.
//  5. Write buf[0x10]=0xAA in the same cycle as the beat reading it (old value 0x10) -> block shows 0x10.
//     A following fetch of the same address shows 0xAA.
//  6. Pulse rst_n low during beat 4 -> out_vld=0, busy=0, in_rdy=1 immediately.
//     The next kick yields a full fresh block with blk_cnt=0.

Source files
------------

// File: rtl/blk2s_pre.sv
// Feed stage ahead of BLK2S: 256-byte message buffer, gathers one block starting at a
// received buffer pointer (wrapping mod 256) and presents it with a running block counter.
module blk2s_pre #(
  parameter int BLK_BYTES  = 64,
  parameter int BEAT_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   kick,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [7:0]             buf_ptr,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [BLK_BYTES*8-1:0] blk_data,
  output logic [31:0]            blk_cnt,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int NB = BLK_BYTES / BEAT_BYTES;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [7:0]             ptr_q;
  logic [BW-1:0]          beat_q;
  logic [BLK_BYTES*8-1:0] blk_data_q;
  logic [31:0]            blk_cnt_q;
  logic                   out_vld_q;
  logic [7:0]             mem_q [256];
  logic [BEAT_BYTES*8-1:0] beat_data_d;
  logic [7:0]             rd_addr_d;

  // Handshakes: a transfer happens on a rising edge where vld & rdy are both high;
  // a source holds vld and its payload until that edge, out_vld never drops early.
  assign in_rdy    = (state_q == IDLE) & ~kick;
  assign busy      = (state_q != IDLE);
  assign out_vld   = out_vld_q;
  assign blk_data  = blk_data_q;
  assign blk_cnt   = blk_cnt_q;
  assign dbg_state = state_q;

  // Buffer is not reset; reads see the pre-edge value when a write lands on the same byte.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    beat_data_d = '0;
    rd_addr_d   = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      rd_addr_d = ptr_q + 8'(int'(beat_q) * BEAT_BYTES + j);
      beat_data_d[j*8 +: 8] = mem_q[rd_addr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      beat_q     <= '0;
      blk_data_q <= '0;
      blk_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (kick) begin
            ptr_q     <= '0;
            blk_cnt_q <= '0;
            beat_q    <= '0;
            state_q   <= FETCH;
          end else if (in_vld) begin
            ptr_q   <= buf_ptr;
            beat_q  <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          blk_data_q[int'(beat_q)*BEAT_BYTES*8 +: BEAT_BYTES*8] <= beat_data_d;
          beat_q <= beat_q + 1'b1;
          if (beat_q == BW'(NB - 1)) begin
            out_vld_q <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (out_rdy) begin
            out_vld_q <= 1'b0;
            blk_cnt_q <= blk_cnt_q + 32'd1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blk2s_pre.sv
// Bench for blk2s_pre: directed vector table, wrap/collision/reset sequences,
// then random pointers and writes checked against a byte-array reference model.
module tb_blk2s_pre;
  localparam int NB = 8;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, kick, in_vld, out_rdy;
  logic [7:0]    wr_addr, wr_data, buf_ptr;
  logic          in_rdy, out_vld, busy;
  logic [DW-1:0] blk_data;
  logic [31:0]   blk_cnt;
  logic [1:0]    dbg_state;

  blk2s_pre #(.BLK_BYTES(64), .BEAT_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .kick(kick), .in_vld(in_vld), .in_rdy(in_rdy), .buf_ptr(buf_ptr),
    .out_vld(out_vld), .out_rdy(out_rdy), .blk_data(blk_data), .blk_cnt(blk_cnt),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  model_buf [256];
  logic [31:0] model_cnt = '0;
  logic [DW+31:0] exp_q[$];

  typedef struct {
    bit kk; bit vv; logic [7:0] ptr; int hold; bit hwr; bit exp_rdy;
    logic [7:0] b0; logic [7:0] b8; logic [7:0] b63; logic [31:0] cnt;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [DW+31:0] act, input logic [DW+31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_block(input logic [7:0] p);
    logic [DW-1:0] b;
    for (int k = 0; k < 64; k++) b[k*8 +: 8] = model_buf[(int'(p) + k) % 256];
    return b;
  endfunction

  task automatic start_blk(input bit kk, input bit vv, input logic [7:0] p, input bit exp_rdy);
    kick = kk; in_vld = vv; buf_ptr = p;
    #1;
    check("in_rdy_at_accept", in_rdy, exp_rdy);
    if (kk) model_cnt = '0;
    exp_q.push_back({model_cnt, model_block(kk ? 8'h00 : p)});
    tick();
    kick = 1'b0; in_vld = 1'b0;
  endtask

  task automatic wait_cmp(input int done);
    int cyc;
    logic [DW+31:0] e;
    cyc = done;
    while (out_vld !== 1'b1 && cyc < NB + 10) begin
      check("in_rdy_fetch", in_rdy, 1'b0);
      tick();
      cyc++;
    end
    check("latency", cyc, NB);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("block", {blk_cnt, blk_data}, e);
  endtask

  task automatic hold_ack(input int hold, input bit hwr);
    logic [DW-1:0] d0;
    logic [31:0]   c0;
    bit            stable;
    d0 = blk_data; c0 = blk_cnt; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (hwr) begin
        wr_en = i[0]; wr_addr = 8'hC0 + 8'(i % 16); wr_data = 8'($urandom);
      end
      tick();
      if (wr_en) model_buf[wr_addr] = wr_data;
      if (blk_data !== d0 || blk_cnt !== c0 || out_vld !== 1'b1 || in_rdy !== 1'b0) stable = 1'b0;
    end
    wr_en = 1'b0;
    if (hold > 0) check("hold_stable", stable, 1'b1);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("after_ack_vld", out_vld, 1'b0);
    check("after_ack_busy", busy, 1'b0);
    model_cnt = model_cnt + 32'd1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; kick = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    wr_addr = '0; wr_data = '0; buf_ptr = '0;
    vecs[0] = '{1'b1, 1'b0, 8'h00, 0,  1'b0, 1'b0, 8'h00, 8'h08, 8'h3F, 32'd0};
    vecs[1] = '{1'b0, 1'b1, 8'hF0, 2,  1'b0, 1'b1, 8'hF0, 8'hF8, 8'h2F, 32'd1};
    vecs[2] = '{1'b0, 1'b1, 8'hF8, 20, 1'b1, 1'b1, 8'hF8, 8'h00, 8'h37, 32'd2};
    vecs[3] = '{1'b1, 1'b1, 8'h55, 1,  1'b0, 1'b0, 8'h00, 8'h08, 8'h3F, 32'd0};
    vecs[4] = '{1'b0, 1'b1, 8'h40, 0,  1'b0, 1'b1, 8'h40, 8'h48, 8'h7F, 32'd1};

    #12;
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_blk", {blk_cnt, blk_data}, '0);
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 256; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = 8'(i);
      tick();
      model_buf[i] = 8'(i);
    end
    wr_en = 1'b0;

    for (int v = 0; v < 5; v++) begin
      start_blk(vecs[v].kk, vecs[v].vv, vecs[v].ptr, vecs[v].exp_rdy);
      wait_cmp(0);
      check($sformatf("vec%0d_b0", v), blk_data[7:0], vecs[v].b0);
      check($sformatf("vec%0d_b8", v), blk_data[71:64], vecs[v].b8);
      check($sformatf("vec%0d_b63", v), blk_data[511:504], vecs[v].b63);
      check($sformatf("vec%0d_cnt", v), blk_cnt, vecs[v].cnt);
      hold_ack(vecs[v].hold, vecs[v].hwr);
    end

    // Write lands on 0x10 at the same edge beat 2 reads it.
    start_blk(1'b1, 1'b0, 8'h00, 1'b0);
    tick(); tick();
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    model_buf[8'h10] = 8'hAA;
    wait_cmp(3);
    check("collide_old", blk_data[16*8 +: 8], 8'h10);
    hold_ack(0, 1'b0);
    start_blk(1'b1, 1'b0, 8'h00, 1'b0);
    wait_cmp(0);
    check("collide_new", blk_data[16*8 +: 8], 8'hAA);
    hold_ack(0, 1'b0);

    // Asynchronous reset with beat counter at 4.
    start_blk(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_vld", out_vld, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_rdy", in_rdy, 1'b1);
    check("midrst_blk", {blk_cnt, blk_data}, '0);
    void'(exp_q.pop_back());
    model_cnt = '0;
    #3 rst_n = 1'b1;
    tick();
    start_blk(1'b1, 1'b0, 8'h00, 1'b0);
    wait_cmp(0);
    check("postrst_cnt", blk_cnt, 32'd0);
    hold_ack(0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      bit kk;
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        wr_en = 1'b1; wr_addr = 8'($urandom); wr_data = 8'($urandom);
        tick();
        model_buf[wr_addr] = wr_data;
      end
      wr_en = 1'b0;
      kk = ($urandom_range(0, 7) == 0);
      start_blk(kk, kk ? 1'($urandom_range(0, 1)) : 1'b1, 8'($urandom), !kk);
      wait_cmp(0);
      hold_ack($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
